// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Round-robin scheduler that shares one multi-cycle ALU among NUM_REQ
//   requesters. A request is latched, issued with a one-cycle alu_valid
//   pulse, and the ALU result is returned to the owning requester. If the
//   ALU stays silent for too long, a watchdog ends the operation with
//   rsp_err set and the block parks in a sticky fault state until reset.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid[NUM_REQ]    per-requester request; held until its req_grant
//   req_mode[2*NUM_REQ]   op per requester (0 mulu, 1 divu, 2 and, 3 or)
//   req_a/req_b[32*N]     operands per requester
//   req_grant[NUM_REQ]    one-hot pulse: request accepted
//   rsp_valid[NUM_REQ]    one-hot pulse: rsp_data/rsp_err valid
//   rsp_data[64]          ALU result (0 on watchdog error), held until next capture
//   rsp_err               watchdog expired for this response
//   busy, fault           not idle / sticky fault
//   alu_valid/mode/in_A/in_B  issue side of the ALU
//   alu_ready, alu_out    ALU result pulse and data
module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 40
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [2*NUM_REQ-1:0]    req_mode,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]      req_grant,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [63:0]             rsp_data,
  output logic                    rsp_err,
  output logic                    busy,
  output logic                    fault,
  output logic                    alu_valid,
  output logic [1:0]              alu_mode,
  output logic [31:0]             alu_in_A,
  output logic [31:0]             alu_in_B,
  input  logic                    alu_ready,
  input  logic [63:0]             alu_out
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_FAULT = 3'd4
  } state_e;

  state_e               state_q;
  logic [IW-1:0]        rr_ptr_q;
  logic [IW-1:0]        idx_q;
  logic [7:0]           cnt_q;
  logic [NUM_REQ-1:0]   req_grant_q;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic [63:0]          rsp_data_q;
  logic                 rsp_err_q;
  logic                 busy_q;
  logic                 fault_q;
  logic                 alu_valid_q;
  logic [1:0]           alu_mode_q;
  logic [31:0]          alu_a_q;
  logic [31:0]          alu_b_q;

  // Round-robin pick: scan rr_ptr, rr_ptr+1, ... wrapping. The loop runs
  // from the farthest offset down so the nearest requester is the one kept.
  logic [IW-1:0] sel_idx;
  logic          sel_found;
  logic [IW:0]   scan;

  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    scan      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan = {1'b0, rr_ptr_q} + (IW+1)'(k);
      if (scan >= (IW+1)'(NUM_REQ)) scan = scan - (IW+1)'(NUM_REQ);
      if (req_valid[scan[IW-1:0]]) begin
        sel_idx   = scan[IW-1:0];
        sel_found = 1'b1;
      end
    end
  end

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  logic [IW-1:0] rr_ptr_d;
  assign rr_ptr_d = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      req_grant_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      fault_q     <= 1'b0;
      alu_valid_q <= 1'b0;
      alu_mode_q  <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
    end else begin
      // pulse outputs default low; states below raise them for one cycle
      req_grant_q <= '0;
      rsp_valid_q <= '0;
      alu_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (sel_found) begin
            idx_q       <= sel_idx;
            alu_mode_q  <= req_mode[{sel_idx, 1'b0} +: 2];
            alu_a_q     <= req_a[{sel_idx, 5'b0} +: 32];
            alu_b_q     <= req_b[{sel_idx, 5'b0} +: 32];
            req_grant_q <= onehot(sel_idx);
            alu_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // ready on the last allowed cycle still counts as a normal result
          if (alu_ready) begin
            rsp_data_q  <= alu_out;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= onehot(idx_q);
            state_q     <= S_RESP;
          end else if (cnt_q == 8'(TIMEOUT)) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= onehot(idx_q);
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_RESP: begin
          rr_ptr_q   <= rr_ptr_d;
          alu_mode_q <= '0;
          alu_a_q    <= '0;
          alu_b_q    <= '0;
          if (rsp_err_q) begin
            fault_q <= 1'b1;
            state_q <= S_FAULT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_FAULT: begin
          state_q <= S_FAULT;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_grant = req_grant_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  assign fault     = fault_q;
  assign alu_valid = alu_valid_q;
  assign alu_mode  = alu_mode_q;
  assign alu_in_A  = alu_a_q;
  assign alu_in_B  = alu_b_q;

endmodule
